// File: rtl/dmem_responder_if.sv
// Load/store handshake bundle between the MEM stage (master) and the data memory (slave).
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_funct3, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_funct3, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle RV32I data memory: one outstanding request, fixed access latency,
// byte/halfword/word lanes with load sign/zero extension.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic            clk,
  input  logic            reset,
  dmem_responder_if.slave bus
);
  localparam int unsigned IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] BYTE_LIMIT = 32'(4 * DEPTH_WORDS);
  localparam logic [3:0]  CNT_INIT   = 4'(LATENCY - 1);

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               write_q, write_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [1:0]         lane_q, lane_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [2:0]         funct3_q, funct3_d;
  logic               err_q, err_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               resp_err_q, resp_err_d;

  logic [31:0]        mem [DEPTH_WORDS];

  logic               req_err;
  logic               mem_we;
  logic [31:0]        rd_word;
  logic [7:0]         rd_byte;
  logic [15:0]        rd_half;
  logic [31:0]        load_data;
  logic [31:0]        wr_data;
  logic [3:0]         wr_be;

  // Legality of the incoming request, judged once when it is latched.
  always_comb begin
    req_err = 1'b0;
    case (bus.req_funct3)
      F3_B:    req_err = 1'b0;
      F3_H:    req_err = bus.req_addr[0];
      F3_W:    req_err = |bus.req_addr[1:0];
      F3_BU:   req_err = bus.req_write;
      F3_HU:   req_err = bus.req_write | bus.req_addr[0];
      default: req_err = 1'b1;
    endcase
    if (bus.req_addr >= BYTE_LIMIT) begin
      req_err = 1'b1;
    end
  end

  always_comb begin
    rd_word   = mem[idx_q];
    rd_byte   = rd_word[{lane_q, 3'b000} +: 8];
    rd_half   = lane_q[1] ? rd_word[31:16] : rd_word[15:0];
    load_data = '0;
    case (funct3_q)
      F3_B:    load_data = {{24{rd_byte[7]}}, rd_byte};
      F3_H:    load_data = {{16{rd_half[15]}}, rd_half};
      F3_W:    load_data = rd_word;
      F3_BU:   load_data = {24'h0, rd_byte};
      F3_HU:   load_data = {16'h0, rd_half};
      default: load_data = '0;
    endcase
  end

  // Store data is replicated across lanes so the byte enables alone pick the target bytes.
  always_comb begin
    wr_data = wdata_q;
    wr_be   = 4'b0000;
    case (funct3_q)
      F3_B: begin
        wr_data = {4{wdata_q[7:0]}};
        wr_be   = 4'b0001 << lane_q;
      end
      F3_H: begin
        wr_data = {2{wdata_q[15:0]}};
        wr_be   = lane_q[1] ? 4'b1100 : 4'b0011;
      end
      F3_W:    wr_be = 4'b1111;
      default: wr_be = 4'b0000;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    write_d    = write_q;
    idx_d      = idx_q;
    lane_d     = lane_q;
    wdata_d    = wdata_q;
    funct3_d   = funct3_q;
    err_d      = err_q;
    rdata_d    = rdata_q;
    resp_err_d = resp_err_q;
    mem_we     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          write_d  = bus.req_write;
          idx_d    = bus.req_addr[IDX_W+1:2];
          lane_d   = bus.req_addr[1:0];
          wdata_d  = bus.req_wdata;
          funct3_d = bus.req_funct3;
          err_d    = req_err;
          cnt_d    = CNT_INIT;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d    = RESP;
          resp_err_d = err_q;
          rdata_d    = '0;
          if (!err_q) begin
            if (write_q) begin
              mem_we = 1'b1;
            end else begin
              rdata_d = load_data;
            end
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (bus.resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      write_q    <= 1'b0;
      idx_q      <= '0;
      lane_q     <= '0;
      wdata_q    <= '0;
      funct3_q   <= '0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      resp_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      write_q    <= write_d;
      idx_q      <= idx_d;
      lane_q     <= lane_d;
      wdata_q    <= wdata_d;
      funct3_q   <= funct3_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      resp_err_q <= resp_err_d;
    end
  end

  // The array is deliberately left out of reset; its contents survive a reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) begin
          mem[idx_q][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = resp_err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: word/subword accesses, errors, response
// back-pressure, reset during an access and back-to-back streaming.
module tb_dmem_responder;
  localparam int unsigned DEPTH_WORDS = 1024;
  localparam int unsigned LATENCY     = 2;
  localparam int          TIMEOUT     = 60;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [2:0]  f3;
    logic [31:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  dmem_responder_if bus ();

  dmem_responder #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .LATENCY    (LATENCY)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    bus.req_funct3 = 3'b000;
    bus.resp_ready = 1'b0;
  endtask

  // Runs one transaction from an IDLE-side sample point; lat = edges from acceptance to resp_valid, -1 on timeout.
  task automatic do_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [2:0] f3, output logic [31:0] rd, output logic er,
                           output int lat);
    int n;
    bus.req_valid  = 1'b1;
    bus.req_write  = w;
    bus.req_addr   = a;
    bus.req_wdata  = d;
    bus.req_funct3 = f3;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < TIMEOUT) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 0;
    while (bus.resp_valid !== 1'b1 && lat < TIMEOUT) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = bus.resp_rdata;
    er = bus.resp_err;
    if (n >= TIMEOUT || lat >= TIMEOUT) lat = -1;
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (bus.req_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_req_ready: got %b want 1", bus.req_ready); end
    total++; if (bus.resp_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_resp_valid: got %b want 0", bus.resp_valid); end
    total++; if (bus.resp_rdata !== 32'h0) begin bad++; $display("[TB] FAIL reset_rdata: got %h want 00000000", bus.resp_rdata); end
    total++; if (bus.resp_err !== 1'b0) begin bad++; $display("[TB] FAIL reset_err: got %b want 0", bus.resp_err); end
    #2;
    reset = 1'b1;
    @(posedge clk); #1;
    total++; if (bus.req_ready !== 1'b1) begin bad++; $display("[TB] FAIL post_reset_ready: got %b want 1", bus.req_ready); end
  endtask

  task automatic test_word();
    logic [31:0] rd;
    logic        er;
    int          lat;
    do_access(1'b1, 32'h10, 32'hDEADBEEF, F3_W, rd, er, lat);
    total++; if (rd !== 32'h0) begin bad++; $display("[TB] FAIL sw_rdata: got %h want 00000000", rd); end
    total++; if (er !== 1'b0) begin bad++; $display("[TB] FAIL sw_err: got %b want 0", er); end
    total++; if (lat != LATENCY) begin bad++; $display("[TB] FAIL sw_latency: got %0d want %0d", lat, LATENCY); end
    do_access(1'b0, 32'h10, 32'h0, F3_W, rd, er, lat);
    total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL lw_rdata: got %h want deadbeef", rd); end
    total++; if (er !== 1'b0) begin bad++; $display("[TB] FAIL lw_err: got %b want 0", er); end
    total++; if (lat != LATENCY) begin bad++; $display("[TB] FAIL lw_latency: got %0d want %0d", lat, LATENCY); end
  endtask

  task automatic test_subword();
    vec_t        v [6];
    logic [31:0] rd;
    logic        er;
    int          lat;
    v[0] = '{1'b1, 32'h11, 32'h0000007F, F3_B,  32'h00000000};
    v[1] = '{1'b0, 32'h10, 32'h0,        F3_W,  32'hDEAD7FEF};
    v[2] = '{1'b0, 32'h13, 32'h0,        F3_B,  32'hFFFFFFDE};
    v[3] = '{1'b0, 32'h13, 32'h0,        F3_BU, 32'h000000DE};
    v[4] = '{1'b0, 32'h12, 32'h0,        F3_H,  32'hFFFFDEAD};
    v[5] = '{1'b0, 32'h12, 32'h0,        F3_HU, 32'h0000DEAD};
    for (int i = 0; i < 6; i++) begin
      do_access(v[i].w, v[i].a, v[i].d, v[i].f3, rd, er, lat);
      total++; if (rd !== v[i].exp) begin bad++; $display("[TB] FAIL subword_rdata[%0d]: got %h want %h", i, rd, v[i].exp); end
      total++; if (er !== 1'b0 || lat != LATENCY) begin bad++; $display("[TB] FAIL subword_status[%0d]: got err=%b lat=%0d want err=0 lat=%0d", i, er, lat, LATENCY); end
    end
  endtask

  task automatic test_errors();
    vec_t        v [5];
    logic [31:0] rd;
    logic        er;
    int          lat;
    v[0] = '{1'b0, 32'h12,              32'h0,        F3_W,   32'h0};
    v[1] = '{1'b0, 32'h13,              32'h0,        F3_H,   32'h0};
    v[2] = '{1'b1, 32'(4*DEPTH_WORDS),  32'h01020304, F3_W,   32'h0};
    v[3] = '{1'b1, 32'h10,              32'h00000055, F3_BU,  32'h0};
    v[4] = '{1'b1, 32'h10,              32'h00000066, 3'b011, 32'h0};
    for (int i = 0; i < 5; i++) begin
      do_access(v[i].w, v[i].a, v[i].d, v[i].f3, rd, er, lat);
      total++; if (er !== 1'b1) begin bad++; $display("[TB] FAIL err_flag[%0d]: got %b want 1", i, er); end
      total++; if (rd !== 32'h0) begin bad++; $display("[TB] FAIL err_rdata[%0d]: got %h want 00000000", i, rd); end
    end
    do_access(1'b0, 32'h10, 32'h0, F3_W, rd, er, lat);
    total++; if (rd !== 32'hDEAD7FEF) begin bad++; $display("[TB] FAIL err_no_write: got %h want dead7fef", rd); end
  endtask

  task automatic test_hold();
    logic [31:0] rd;
    logic        er;
    int          n;
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b0;
    bus.req_addr   = 32'h10;
    bus.req_funct3 = F3_W;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    n = 0;
    while (bus.resp_valid !== 1'b1 && n < TIMEOUT) begin
      @(posedge clk); #1;
      n++;
    end
    total++; if (n != LATENCY) begin bad++; $display("[TB] FAIL hold_latency: got %0d want %0d", n, LATENCY); end
    for (int i = 0; i < 5; i++) begin
      total++; if (bus.resp_valid !== 1'b1 || bus.req_ready !== 1'b0) begin bad++; $display("[TB] FAIL hold_handshake[%0d]: got valid=%b ready=%b want valid=1 ready=0", i, bus.resp_valid, bus.req_ready); end
      total++; if (bus.resp_rdata !== 32'hDEAD7FEF || bus.resp_err !== 1'b0) begin bad++; $display("[TB] FAIL hold_data[%0d]: got %h err=%b want dead7fef err=0", i, bus.resp_rdata, bus.resp_err); end
      bus.req_valid  = (i % 2 == 0);
      bus.req_write  = 1'b1;
      bus.req_addr   = 32'h10;
      bus.req_wdata  = 32'h0;
      bus.req_funct3 = F3_W;
      @(posedge clk); #1;
    end
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    total++; if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin bad++; $display("[TB] FAIL hold_release: got valid=%b ready=%b want valid=0 ready=1", bus.resp_valid, bus.req_ready); end
    do_access(1'b0, 32'h10, 32'h0, F3_W, rd, er, n);
    total++; if (rd !== 32'hDEAD7FEF) begin bad++; $display("[TB] FAIL hold_ignored_store: got %h want dead7fef", rd); end
  endtask

  task automatic test_reset_busy();
    logic [31:0] rd;
    logic        er;
    int          lat;
    do_access(1'b1, 32'h20, 32'h0, F3_W, rd, er, lat);
    do_access(1'b0, 32'h10, 32'h0, F3_W, rd, er, lat);
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b1;
    bus.req_addr   = 32'h20;
    bus.req_wdata  = 32'h12345678;
    bus.req_funct3 = F3_W;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    total++; if (bus.req_ready !== 1'b0) begin bad++; $display("[TB] FAIL rst_busy_entered: got %b want 0", bus.req_ready); end
    #2;
    reset = 1'b0;
    #1;
    total++; if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_busy_handshake: got ready=%b valid=%b want ready=1 valid=0", bus.req_ready, bus.resp_valid); end
    total++; if (bus.resp_rdata !== 32'h0 || bus.resp_err !== 1'b0) begin bad++; $display("[TB] FAIL rst_busy_outputs: got %h err=%b want 00000000 err=0", bus.resp_rdata, bus.resp_err); end
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;
    @(posedge clk); #1;
    do_access(1'b0, 32'h20, 32'h0, F3_W, rd, er, lat);
    total++; if (rd !== 32'h0 || er !== 1'b0) begin bad++; $display("[TB] FAIL rst_busy_no_write: got %h err=%b want 00000000 err=0", rd, er); end
  endtask

  task automatic test_back_to_back();
    vec_t v [8];
    int   k;
    int   cyc;
    int   last;
    v[0] = '{1'b1, 32'h40, 32'h11223344, F3_W,  32'h00000000};
    v[1] = '{1'b1, 32'h42, 32'hAAAA8001, F3_H,  32'h00000000};
    v[2] = '{1'b0, 32'h40, 32'h0,        F3_W,  32'h80013344};
    v[3] = '{1'b1, 32'h40, 32'h000000F0, F3_B,  32'h00000000};
    v[4] = '{1'b0, 32'h42, 32'h0,        F3_H,  32'hFFFF8001};
    v[5] = '{1'b0, 32'h40, 32'h0,        F3_BU, 32'h000000F0};
    v[6] = '{1'b0, 32'h41, 32'h0,        F3_B,  32'h00000033};
    v[7] = '{1'b0, 32'h40, 32'h0,        F3_HU, 32'h000033F0};
    k    = 0;
    cyc  = 0;
    last = 0;
    bus.req_write  = v[0].w;
    bus.req_addr   = v[0].a;
    bus.req_wdata  = v[0].d;
    bus.req_funct3 = v[0].f3;
    bus.req_valid  = 1'b1;
    bus.resp_ready = 1'b1;
    while (k < 8 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (bus.resp_valid === 1'b1) begin
        total++; if (bus.resp_rdata !== v[k].exp || bus.resp_err !== 1'b0) begin bad++; $display("[TB] FAIL b2b_data[%0d]: got %h err=%b want %h err=0", k, bus.resp_rdata, bus.resp_err, v[k].exp); end
        if (k > 0) begin
          total++; if (cyc - last != LATENCY + 2) begin bad++; $display("[TB] FAIL b2b_spacing[%0d]: got %0d want %0d", k, cyc - last, LATENCY + 2); end
        end
        last = cyc;
        k++;
        if (k < 8) begin
          bus.req_write  = v[k].w;
          bus.req_addr   = v[k].a;
          bus.req_wdata  = v[k].d;
          bus.req_funct3 = v[k].f3;
        end else begin
          bus.req_valid = 1'b0;
        end
      end
    end
    total++; if (k != 8) begin bad++; $display("[TB] FAIL b2b_count: got %0d want 8", k); end
    @(posedge clk); #1;
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_word();
    test_subword();
    test_errors();
    test_hold();
    test_reset_busy();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
